seg_display_scan: RTL and testbench
===================================

Name: seg_display_scan

Overview:
- Display back end for the stopwatch counter: takes the four BCD time digits (min1, min0, sec1, sec0) plus the adjust and select controls, and drives a 4-digit common-anode seven-segment display.
- Time-multiplexes one digit per refresh slot and snapshots all four digits once per frame so the display never tears.
- In adjust mode, blinks the digit pair being adjusted.

Parameters:
- REFRESH_DIV, 100000, clocks per digit slot; minimum 2 (1 kHz slot rate at 100 MHz).
- BLINK_DIV, 25000000, clocks per blink half-period; minimum 2.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous reset, active-low.
- min1  input  4  BCD tens of minutes.
- min0  input  4  BCD units of minutes.
- sec1  input  4  BCD tens of seconds.
- sec0  input  4  BCD units of seconds.
- adjust  input  1  1 = adjust mode, enables blinking.
- select  input  1  in adjust mode: 1 = seconds pair selected, 0 = minutes pair selected.
- an  output  4  anode enables, active-low; an[0]=sec0, an[1]=sec1, an[2]=min0, an[3]=min1.
- seg  output  7  cathodes, active-low, ordered {g,f,e,d,c,b,a}.
- dp  output  1  decimal point, active-low.

Behaviour:
- Reset (async, reset_n=0):
  - an=4'b1111, seg=7'b1111111, dp=1.
  - ref_cnt=0, idx=0, blink_cnt=0, blink_ph=0, all shadow digits 0.
- Refresh counter: ref_cnt counts 0..REFRESH_DIV-1 and wraps. On wrap, idx advances 0→1→2→3→0. Counter width is $clog2(REFRESH_DIV).
- Snapshot: at the clock edge where idx==0 and ref_cnt==0, all four inputs are latched into shadow registers. Inputs are sampled at no other time. An input change becomes visible in the frame that starts after the change.
- Outputs are registered and reflect idx, ref_cnt and shadow from the previous cycle.
- Dead time: for the output cycle following ref_cnt==0, an=1111 (ghost suppression). seg and dp still update during this cycle.
- Active cycles (ref_cnt≥1): an = one-hot-low of idx unless the digit is blanked. seg = decode(shadow[idx]).
- dp=0 only in slot 2 while that slot is lit. Otherwise dp=1.
- Decode table:
  - 0 → 1000000, 1 → 1111001, 2 → 0100100, 3 → 0110000, 4 → 0011001.
  - 5 → 0010010, 6 → 0000010, 7 → 1111000, 8 → 0000000, 9 → 0010000.
  - Codes 10–15 → 0111111 (dash, segment g only).
- Blink:
  - While adjust=1, blink_cnt counts 0..BLINK_DIV-1; on wrap, blink_ph toggles.
  - While adjust=0, blink_cnt and blink_ph are held at 0. Entering adjust therefore always starts with a lit half-period.
- Blanking: when adjust=1 and blink_ph=1, slots 0–1 are forced off if select=1, and slots 2–3 are forced off if select=0 (an bit=1, dp=1).
  - select changes take effect on the next output cycle.
  - A drop of adjust unblanks on the next output cycle.
- reset_n asserted mid-slot forces the reset outputs immediately. Scanning restarts at slot 0 with a fresh snapshot on the first clock after release.

Optional Feature:
- Macro SEG_LZB_EN.
- Defined: leading-zero blanking. When shadow min1==0, slot 3 is never lit (an[3]=1). Slots 0–2 are unaffected, and a zero in min0 still displays.
- Undefined: min1==0 displays as 1000000 like any other digit.

Test Plan:
- Reset mid-slot 2 with adjust=0 → an=1111, seg=1111111, dp=1 with no clock needed; after release the scan resumes from slot 0.
- REFRESH_DIV=4; inputs min1=1, min0=2, sec1=3, sec0=4; adjust=0 → each 4-cycle slot gives 1 dead cycle (an=1111) then 3 cycles of:
  - an=1110, seg=0011001
  - an=1101, seg=0110000
  - an=1011, seg=0100100, dp=0
  - an=0111, seg=1111001
  - repeating every 16 cycles.
- Tearing: change sec0 4→5 while idx=2 → the current frame is unchanged; the next frame's slot 0 shows seg=0010010.
- sec1=4'hC → slot 1 shows seg=0111111.
- BLINK_DIV=8; adjust=1, select=1 → slots 0–1 lit for 8 cycles and dark for 8 cycles alternately, slots 2–3 never dark. With select=0, the mirror image. Dropping adjust gives full display next cycle.
- min1=0 → with SEG_LZB_EN, an[3] stays 1 for the whole frame; without it, slot 3 shows seg=1000000.

Source files
------------

// File: rtl/seg_display_scan.sv
// seg_display_scan
//   Display back end for the stopwatch. It scans four BCD digits onto a
//   4-digit common-anode seven-segment display, one digit per refresh slot.
//   All four digits are snapshotted once per frame, so a frame never shows
//   a mix of old and new time. In adjust mode the digit pair being adjusted
//   blinks.
//
//   Optional feature: define SEG_LZB_EN to enable leading-zero blanking.
//   With it, slot 3 (tens of minutes) stays dark whenever its snapshot is 0.
//
// Parameters
//   REFRESH_DIV : clocks per digit slot (>= 2)
//   BLINK_DIV   : clocks per blink half-period (>= 2)
//
// Ports
//   clk, reset_n           : clock, asynchronous active-low reset
//   min1, min0, sec1, sec0 : BCD digits to display
//   adjust                 : 1 = adjust mode (blinking enabled)
//   select                 : in adjust mode, 1 = seconds pair, 0 = minutes pair
//   an[3:0]                : anode enables, active-low (an[0] = sec0 ... an[3] = min1)
//   seg[6:0]               : cathodes {g,f,e,d,c,b,a}, active-low
//   dp                     : decimal point, active-low (lit in slot 2)
module seg_display_scan #(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 25000000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] min1,
   input  logic [3:0] min0,
   input  logic [3:0] sec1,
   input  logic [3:0] sec0,
   input  logic       adjust,
   input  logic       select,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int RW = $clog2(REFRESH_DIV);
   localparam int BW = $clog2(BLINK_DIV);
   localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [RW-1:0]     ref_cnt_q, ref_cnt_d;
   logic [1:0]        idx_q, idx_d;
   logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
   logic              blink_ph_q, blink_ph_d;
   // shadow_q[0] = sec0, [1] = sec1, [2] = min0, [3] = min1
   logic [3:0][3:0]   shadow_q, shadow_d;
   logic [3:0]        an_q, an_d;
   logic [6:0]        seg_q, seg_d;
   logic              dp_q, dp_d;

   logic              ref_wrap;
   logic              blank;
   logic              lit;

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;   // non-BCD code shows a dash
      endcase
      return s;
   endfunction

   // Scan counters, frame snapshot and blink timing.
   always_comb begin
      ref_wrap  = (ref_cnt_q == REF_LAST);
      ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + RW'(1);
      idx_d     = ref_wrap ? idx_q + 2'd1 : idx_q;

      shadow_d = shadow_q;
      if (idx_q == 2'd0 && ref_cnt_q == '0)
         shadow_d = {min1, min0, sec1, sec0};

      // Held at zero outside adjust so every adjust entry starts lit.
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
      if (adjust) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
            blink_ph_d  = blink_ph_q;
         end
      end
   end

   // Registered display outputs, derived from this cycle's scan state.
   always_comb begin
      // select = 1 blanks the seconds slots (idx 0,1), select = 0 the minutes slots (idx 2,3)
      blank = adjust && blink_ph_q && (select ? !idx_q[1] : idx_q[1]);
`ifdef SEG_LZB_EN
      if (idx_q == 2'd3 && shadow_q[3] == 4'd0)
         blank = 1'b1;
`endif
      // First cycle of each slot is dead time to suppress ghosting.
      lit = (ref_cnt_q != '0) && !blank;

      an_d = 4'b1111;
      if (lit)
         an_d[idx_q] = 1'b0;
      seg_d = decode(shadow_q[idx_q]);
      dp_d  = !(lit && idx_q == 2'd2);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ref_cnt_q   <= '0;
         idx_q       <= '0;
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b0;
         shadow_q    <= '0;
         an_q        <= '1;
         seg_q       <= '1;
         dp_q        <= 1'b1;
      end else begin
         ref_cnt_q   <= ref_cnt_d;
         idx_q       <= idx_d;
         blink_cnt_q <= blink_cnt_d;
         blink_ph_q  <= blink_ph_d;
         shadow_q    <= shadow_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// tb_seg_display_scan
//   Directed bench for seg_display_scan with REFRESH_DIV=4 and BLINK_DIV=8.
//   The stimulus process queues the expected {an,seg,dp} for every output
//   cycle; a monitor process pops and compares after each clock edge (and
//   once on demand for the asynchronous reset check).
module tb_seg_display_scan;

   localparam logic [6:0] S0   = 7'b1000000;
   localparam logic [6:0] S1   = 7'b1111001;
   localparam logic [6:0] S2   = 7'b0100100;
   localparam logic [6:0] S3   = 7'b0110000;
   localparam logic [6:0] S4   = 7'b0011001;
   localparam logic [6:0] S5   = 7'b0010010;
   localparam logic [6:0] DASH = 7'b0111111;
   localparam logic [6:0] OFF  = 7'b1111111;

`ifdef SEG_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] min1, min0, sec1, sec0;
   logic       adjust, select;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   exp_t        sb[$];
   event        ev_async;
   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   seg_display_scan #(
      .REFRESH_DIV(4),
      .BLINK_DIV  (8)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .min1   (min1),
      .min0   (min0),
      .sec1   (sec1),
      .sec0   (sec0),
      .adjust (adjust),
      .select (select),
      .an     (an),
      .seg    (seg),
      .dp     (dp)
   );

   always #5 clk = ~clk;

   task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d);
      exp_t e;
      e.an  = a;
      e.seg = s;
      e.dp  = d;
      sb.push_back(e);
   endtask

   // Queue the expectation for the output after the next clock edge.
   task automatic chk(input logic [3:0] a, input logic [6:0] s, input logic d);
      push(a, s, d);
      @(negedge clk);
   endtask

   // One 4-cycle slot: dead cycle, then three cycles lit (or blanked).
   task automatic slot(input int s, input logic [6:0] dead_seg,
                       input logic [6:0] act_seg, input bit lit);
      logic [3:0] a;
      a = 4'b1111;
      if (lit)
         a[s] = 1'b0;
      chk(4'b1111, dead_seg, 1'b1);
      for (int r = 1; r < 4; r++)
         chk(a, act_seg, (lit && s == 2) ? 1'b0 : 1'b1);
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk or ev_async);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
               miscompares++;
               $display("FAIL out vec %0d @%0t: an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
                        vectors, $time, an, seg, dp, e.an, e.seg, e.dp);
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
      $fatal(1);
   end

   // Stimulus
   initial begin
      reset_n = 1'b0;
      min1 = 4'd1; min0 = 4'd2; sec1 = 4'd3; sec0 = 4'd4;
      adjust = 1'b0; select = 1'b0;
      @(negedge clk);
      chk(4'b1111, OFF, 1'b1);
      chk(4'b1111, OFF, 1'b1);
      reset_n = 1'b1;

      // Frame A: dead cycle of slot 0 still shows the reset-time shadow (0)
      slot(0, S0, S4, 1'b1);
      slot(1, S3, S3, 1'b1);
      slot(2, S2, S2, 1'b1);
      slot(3, S1, S1, 1'b1);

      // Frame B: sec0 changes during slot 2, must not tear this frame
      slot(0, S4, S4, 1'b1);
      slot(1, S3, S3, 1'b1);
      sec0 = 4'd5;
      slot(2, S2, S2, 1'b1);
      slot(3, S1, S1, 1'b1);

      // Frame C: new sec0 appears; sec1 goes non-BCD for the next frame
      slot(0, S4, S5, 1'b1);
      sec1 = 4'hC;
      slot(1, S3, S3, 1'b1);
      slot(2, S2, S2, 1'b1);
      slot(3, S1, S1, 1'b1);

      // Frame D: dash in slot 1
      slot(0, S5, S5, 1'b1);
      slot(1, DASH, DASH, 1'b1);
      slot(2, S2, S2, 1'b1);
      slot(3, S1, S1, 1'b1);

      // Frame E: asynchronous reset in the middle of slot 2
      slot(0, S5, S5, 1'b1);
      slot(1, DASH, DASH, 1'b1);
      chk(4'b1111, S2, 1'b1);
      chk(4'b1011, S2, 1'b0);
      #2;
      reset_n = 1'b0;
      push(4'b1111, OFF, 1'b1);
      -> ev_async;
      #2;
      @(negedge clk);
      chk(4'b1111, OFF, 1'b1);
      reset_n = 1'b1;

      // Frame F: scan restarts at slot 0 with a fresh snapshot
      slot(0, S0, S5, 1'b1);
      slot(1, DASH, DASH, 1'b1);
      slot(2, S2, S2, 1'b1);
      slot(3, S1, S1, 1'b1);

      // Frame G: enter adjust (minutes selected) at the start of slot 1;
      // the blink dark half then covers slots 3 and 0
      slot(0, S5, S5, 1'b1);
      adjust = 1'b1;
      select = 1'b0;
      slot(1, DASH, DASH, 1'b1);
      slot(2, S2, S2, 1'b1);
      slot(3, S1, S1, 1'b0);

      // Frame H: select switched mid-slot 3 relights it on the next cycle
      slot(0, S5, S5, 1'b1);
      slot(1, DASH, DASH, 1'b1);
      slot(2, S2, S2, 1'b1);
      chk(4'b1111, S1, 1'b1);
      chk(4'b1111, S1, 1'b1);
      select = 1'b1;
      chk(4'b0111, S1, 1'b1);
      chk(4'b0111, S1, 1'b1);

      // Frame I: seconds selected, slot 0 dark, slot 3 lit
      slot(0, S5, S5, 1'b0);
      slot(1, DASH, DASH, 1'b1);
      slot(2, S2, S2, 1'b1);
      slot(3, S1, S1, 1'b1);

      // Frame J: dropping adjust mid dark half unblanks on the next cycle
      chk(4'b1111, S5, 1'b1);
      chk(4'b1111, S5, 1'b1);
      adjust = 1'b0;
      chk(4'b1110, S5, 1'b1);
      chk(4'b1110, S5, 1'b1);
      slot(1, DASH, DASH, 1'b1);
      min1 = 4'd0;
      slot(2, S2, S2, 1'b1);
      slot(3, S1, S1, 1'b1);

      // Frame K: min1 = 0, blanked only with leading-zero blanking
      slot(0, S5, S5, 1'b1);
      slot(1, DASH, DASH, 1'b1);
      slot(2, S2, S2, 1'b1);
      slot(3, S0, S0, !LZB);

      @(posedge clk);
      #2;
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
